// File: rtl/shared_alu_arbiter.sv
// shared_alu_arbiter: one combinational ALU shared by N_REQ requesters.
// Round-robin grant on req_valid/req_ready; result held in a one-entry
// buffer and returned on resp_valid/resp_ready/resp_data.
// Ports: clk, reset (sync, active-high), req_valid/ready [N_REQ],
//   req_op [3*N_REQ], req_left/right [WIDTH*N_REQ],
//   resp_valid/ready [N_REQ], resp_data [WIDTH].
module shared_alu_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [3*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_left,
  input  logic [WIDTH*N_REQ-1:0] req_right,
  output logic [N_REQ-1:0]       resp_valid,
  input  logic [N_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]       resp_data
);

  localparam logic [ID_W:0] NR = (ID_W+1)'(N_REQ);

  logic             buf_full;
  logic [ID_W-1:0]  buf_id;
  logic [ID_W-1:0]  rr_ptr;
  logic [WIDTH-1:0] buf_data;

  logic             drain;
  logic             can_accept;
  logic             found;
  logic             grant;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W:0]    nxt;
  logic [2:0]       op_g;
  logic [WIDTH-1:0] a_g;
  logic [WIDTH-1:0] b_g;
  logic [WIDTH-1:0] alu_y;

  // A buffer emptied this cycle may be refilled in the same edge.
  assign drain      = buf_full & resp_ready[buf_id];
  assign can_accept = !reset & (!buf_full | drain);
  assign grant      = can_accept & found;

  // First valid requester at or after rr_ptr, wrapping mod N_REQ.
  always_comb begin
    logic [ID_W:0] s;
    found  = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      s = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (s >= NR) s = s - NR;
      if (!found && req_valid[s[ID_W-1:0]]) begin
        found  = 1'b1;
        gnt_id = s[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i]  = grant && (gnt_id == ID_W'(i));
      resp_valid[i] = buf_full && (buf_id == ID_W'(i));
    end
  end

  assign op_g = req_op[3*int'(gnt_id) +: 3];
  assign a_g  = req_left[WIDTH*int'(gnt_id) +: WIDTH];
  assign b_g  = req_right[WIDTH*int'(gnt_id) +: WIDTH];

  always_comb begin
    alu_y = '0;
    unique case (op_g)
      3'd0: alu_y = a_g + b_g;
      3'd1: alu_y = a_g - b_g;
      3'd2: alu_y = a_g * b_g;
      3'd3: alu_y = a_g & b_g;
      3'd4: alu_y = a_g | b_g;
      3'd5: alu_y = a_g ^ b_g;
      3'd6: alu_y = {{(WIDTH-1){1'b0}}, a_g < b_g};
      3'd7: alu_y = {{(WIDTH-1){1'b0}}, a_g == b_g};
    endcase
  end

  always_comb begin
    nxt = {1'b0, gnt_id} + 1'b1;
    if (nxt == NR) nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_id   <= '0;
      buf_data <= '0;
      rr_ptr   <= '0;
    end else if (grant) begin
      buf_full <= 1'b1;
      buf_id   <= gnt_id;
      buf_data <= alu_y;
      rr_ptr   <= nxt[ID_W-1:0];
    end else if (drain) begin
      buf_full <= 1'b0;
    end
  end

  assign resp_data = buf_data;

endmodule
